// File: rtl/sr_ff_bank.sv
// -----------------------------------------------------------------------------
// sr_ff_bank
//   Bank of N independent, clocked SR flip-flops with per-channel enable and
//   a deterministic resolution of the S=R=1 input. Each channel keeps a sticky
//   conflict flag. An optional saturating counter tallies the clock edges on
//   which any channel saw a conflict.
//
// Configuration macro:
//   SR_FF_BANK_CONFLICT_CNT_EN  defined   -> CNT_W-bit conflict counter built in
//                               undefined -> CONFLICT_CNT tied to 0
//
// Parameters:
//   N        number of channels (1..32)
//   MODE     S=R=1 resolution: 0 hold, 1 set, 2 reset, 3 toggle
//   RST_VAL  reset / clear value of Q
//   CNT_W    width of the conflict counter (2..16)
//
// Ports:
//   CLK           clock, rising edge
//   RST_N         asynchronous active-low reset
//   EN[N]         per-channel enable
//   S[N], R[N]    per-channel set / reset requests
//   CLR           synchronous clear of Q to RST_VAL
//   CONFLICT_ACK  synchronous clear of CONFLICT and CONFLICT_CNT
//   Q[N]          registered state
//   not_Q[N]      bitwise complement of Q
//   CONFLICT[N]   sticky per-channel conflict flag
//   CONFLICT_CNT  saturating count of conflict edges
// -----------------------------------------------------------------------------
module sr_ff_bank #(
  parameter int               N       = 8,
  parameter int               MODE    = 0,
  parameter logic [N-1:0]     RST_VAL = '0,
  parameter int               CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N-1:0]     EN,
  input  logic [N-1:0]     S,
  input  logic [N-1:0]     R,
  input  logic             CLR,
  input  logic             CONFLICT_ACK,
  output logic [N-1:0]     Q,
  output logic [N-1:0]     not_Q,
  output logic [N-1:0]     CONFLICT,
  output logic [CNT_W-1:0] CONFLICT_CNT
);

  logic [N-1:0] r_q;
  logic [N-1:0] r_conflict;

  logic [N-1:0] w_set;
  logic [N-1:0] w_rst;
  logic [N-1:0] w_conflict;
  logic [N-1:0] w_conf_val;
  logic [N-1:0] w_q_basic;
  logic [N-1:0] w_q_next;
  logic [N-1:0] w_conflict_next;

  // Decode the request per channel. The three classes are mutually exclusive,
  // so the conflict bits never see w_set/w_rst activity.
  assign w_set      = EN & S & ~R;
  assign w_rst      = EN & R & ~S;
  assign w_conflict = EN & S & R;

  // Value a conflicting channel resolves to; MODE is a constant so only one
  // arm survives elaboration.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the signal
    // unassigned, which would otherwise infer a latch.
    w_conf_val = r_q;
    case (MODE)
      1:       w_conf_val = '1;
      2:       w_conf_val = '0;
      3:       w_conf_val = ~r_q;
      default: w_conf_val = r_q;
    endcase
  end

  assign w_q_basic = (r_q | w_set) & ~w_rst;
  assign w_q_next  = CLR ? RST_VAL
                         : (w_q_basic & ~w_conflict) | (w_conf_val & w_conflict);

  // A new conflict beats an acknowledge on the same edge.
  assign w_conflict_next = (r_conflict & ~{N{CONFLICT_ACK}}) | w_conflict;

  // NOTE: every state register is reset and updated with non-blocking
  // assignments so all flops sample their inputs on the same edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_q        <= RST_VAL;
      r_conflict <= '0;
    end else begin
      r_q        <= w_q_next;
      r_conflict <= w_conflict_next;
    end
  end

  assign Q        = r_q;
  assign not_Q    = ~r_q;
  assign CONFLICT = r_conflict;

`ifdef SR_FF_BANK_CONFLICT_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             w_any_conflict;
  logic             w_cnt_sat;

  assign w_any_conflict = |w_conflict;
  assign w_cnt_sat      = (r_cnt == {CNT_W{1'b1}});

  // One increment per conflicting edge, however many channels conflict.
  // ACK with a conflict restarts the count at 1 rather than 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (w_any_conflict) begin
      if (CONFLICT_ACK)
        r_cnt <= CNT_W'(1);
      else if (!w_cnt_sat)
        r_cnt <= r_cnt + CNT_W'(1);
    end else if (CONFLICT_ACK) begin
      r_cnt <= '0;
    end
  end

  assign CONFLICT_CNT = r_cnt;
`else
  assign CONFLICT_CNT = '0;
`endif

endmodule

// File: tb/tb_sr_ff_bank.sv
// -----------------------------------------------------------------------------
// tb_sr_ff_bank
//   Directed bench for sr_ff_bank. Four instances (MODE 0..3) share the same
//   stimulus with N=8, RST_VAL=8'h0F, CNT_W=2; expected values are written
//   by hand per scenario. Counter expectations follow the build macro.
// -----------------------------------------------------------------------------
module tb_sr_ff_bank;

`ifdef SR_FF_BANK_CONFLICT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] en, s, r;
  logic       clr, ack;

  logic [7:0] q0, q1, q2, q3;
  logic [7:0] nq0, nq1, nq2, nq3;
  logic [7:0] cf0, cf1, cf2, cf3;
  logic [1:0] cn0, cn1, cn2, cn3;

  int checks = 0;
  int errors = 0;

  sr_ff_bank #(.N(8), .MODE(0), .RST_VAL(8'h0F), .CNT_W(2)) u_m0 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .S(s), .R(r), .CLR(clr),
    .CONFLICT_ACK(ack), .Q(q0), .not_Q(nq0), .CONFLICT(cf0), .CONFLICT_CNT(cn0));
  sr_ff_bank #(.N(8), .MODE(1), .RST_VAL(8'h0F), .CNT_W(2)) u_m1 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .S(s), .R(r), .CLR(clr),
    .CONFLICT_ACK(ack), .Q(q1), .not_Q(nq1), .CONFLICT(cf1), .CONFLICT_CNT(cn1));
  sr_ff_bank #(.N(8), .MODE(2), .RST_VAL(8'h0F), .CNT_W(2)) u_m2 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .S(s), .R(r), .CLR(clr),
    .CONFLICT_ACK(ack), .Q(q2), .not_Q(nq2), .CONFLICT(cf2), .CONFLICT_CNT(cn2));
  sr_ff_bank #(.N(8), .MODE(3), .RST_VAL(8'h0F), .CNT_W(2)) u_m3 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .S(s), .R(r), .CLR(clr),
    .CONFLICT_ACK(ack), .Q(q3), .not_Q(nq3), .CONFLICT(cf3), .CONFLICT_CNT(cn3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] e, input logic [7:0] sv,
                       input logic [7:0] rv, input logic c, input logic a);
    en = e; s = sv; r = rv; clr = c; ack = a;
  endtask

  function automatic logic [1:0] ecnt(input int v);
    return CNT_ON ? 2'(v) : 2'd0;
  endfunction

  task automatic test_reset();
    // Disturb state first so the reset has something to discard.
    drive(8'hFF, 8'hF0, 8'hF1, 1'b0, 1'b0);
    step();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({q0, q1, q2, q3} !== {4{8'h0F}}) begin
      errors++; $display("FAIL reset_q got %h want %h", {q0, q1, q2, q3}, {4{8'h0F}});
    end
    checks++;
    if ({nq0, nq1, nq2, nq3} !== {4{8'hF0}}) begin
      errors++; $display("FAIL reset_nq got %h want %h", {nq0, nq1, nq2, nq3}, {4{8'hF0}});
    end
    checks++;
    if ({cf0, cf1, cf2, cf3} !== 32'h0) begin
      errors++; $display("FAIL reset_conflict got %h want 0", {cf0, cf1, cf2, cf3});
    end
    checks++;
    if ({cn0, cn1, cn2, cn3} !== 8'h0) begin
      errors++; $display("FAIL reset_cnt got %h want 0", {cn0, cn1, cn2, cn3});
    end
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    drive(8'hFF, 8'h80, 8'h01, 1'b0, 1'b0);
    step();
    checks++;
    if ({q0, q1, q2, q3} !== {4{8'h8E}}) begin
      errors++; $display("FAIL basic_set got %h want %h", {q0, q1, q2, q3}, {4{8'h8E}});
    end
    checks++;
    if ({nq0, nq1, nq2, nq3} !== {4{8'h71}}) begin
      errors++; $display("FAIL basic_nq got %h want %h", {nq0, nq1, nq2, nq3}, {4{8'h71}});
    end
    drive(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
    step();
    checks++;
    if ({q0, q1, q2, q3} !== {4{8'h8E}}) begin
      errors++; $display("FAIL basic_en_hold got %h want %h", {q0, q1, q2, q3}, {4{8'h8E}});
    end
    checks++;
    if ({cf0, cf1, cf2, cf3} !== 32'h0) begin
      errors++; $display("FAIL basic_conflict got %h want 0", {cf0, cf1, cf2, cf3});
    end
  endtask

  task automatic test_forbidden();
    drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    step();
    checks++;
    if ({q0, q1, q2, q3} !== {4{8'h0F}}) begin
      errors++; $display("FAIL forbid_pre_clr got %h want %h", {q0, q1, q2, q3}, {4{8'h0F}});
    end
    drive(8'h01, 8'h01, 8'h01, 1'b0, 1'b0);
    step();
    checks++;
    if ({q0, q1, q2, q3} !== {8'h0F, 8'h0F, 8'h0E, 8'h0E}) begin
      errors++; $display("FAIL forbid_edge1 got %h want %h", {q0, q1, q2, q3},
                         {8'h0F, 8'h0F, 8'h0E, 8'h0E});
    end
    checks++;
    if ({nq0, nq1, nq2, nq3} !== {8'hF0, 8'hF0, 8'hF1, 8'hF1}) begin
      errors++; $display("FAIL forbid_nq got %h want %h", {nq0, nq1, nq2, nq3},
                         {8'hF0, 8'hF0, 8'hF1, 8'hF1});
    end
    step();
    checks++;
    if ({q0, q1, q2, q3} !== {8'h0F, 8'h0F, 8'h0E, 8'h0F}) begin
      errors++; $display("FAIL forbid_edge2 got %h want %h", {q0, q1, q2, q3},
                         {8'h0F, 8'h0F, 8'h0E, 8'h0F});
    end
    checks++;
    if ({cf0, cf1, cf2, cf3} !== {4{8'h01}}) begin
      errors++; $display("FAIL forbid_conflict got %h want %h", {cf0, cf1, cf2, cf3}, {4{8'h01}});
    end
    checks++;
    if ({cn0, cn1, cn2, cn3} !== {4{ecnt(2)}}) begin
      errors++; $display("FAIL forbid_cnt got %h want %h", {cn0, cn1, cn2, cn3}, {4{ecnt(2)}});
    end
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    step();
    checks++;
    if ({cf0, cf1, cf2, cf3, cn0, cn1, cn2, cn3} !== 40'h0) begin
      errors++; $display("FAIL forbid_ack got %h want 0", {cf0, cf1, cf2, cf3, cn0, cn1, cn2, cn3});
    end
  endtask

  task automatic test_clr();
    drive(8'hFF, 8'hF0, 8'h0F, 1'b0, 1'b0);
    step();
    checks++;
    if ({q0, q1, q2, q3} !== {4{8'hF0}}) begin
      errors++; $display("FAIL clr_setup got %h want %h", {q0, q1, q2, q3}, {4{8'hF0}});
    end
    drive(8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0);
    step();
    checks++;
    if ({q0, q1, q2, q3} !== {4{8'h0F}}) begin
      errors++; $display("FAIL clr_over_set got %h want %h", {q0, q1, q2, q3}, {4{8'h0F}});
    end
    drive(8'hFF, 8'hF0, 8'h0F, 1'b0, 1'b0);
    step();
    drive(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
    step();
    checks++;
    if ({q0, q1, q2, q3} !== {4{8'h0F}}) begin
      errors++; $display("FAIL clr_conflict_q got %h want %h", {q0, q1, q2, q3}, {4{8'h0F}});
    end
    checks++;
    if ({cf0, cf1, cf2, cf3} !== {4{8'hFF}}) begin
      errors++; $display("FAIL clr_conflict_flag got %h want %h", {cf0, cf1, cf2, cf3}, {4{8'hFF}});
    end
    checks++;
    if ({cn0, cn1, cn2, cn3} !== {4{ecnt(1)}}) begin
      errors++; $display("FAIL clr_conflict_cnt got %h want %h", {cn0, cn1, cn2, cn3}, {4{ecnt(1)}});
    end
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    step();
  endtask

  task automatic test_counter();
    logic [1:0] want [4];
    want[0] = ecnt(1); want[1] = ecnt(2); want[2] = ecnt(3); want[3] = ecnt(3);
    drive(8'h01, 8'h01, 8'h01, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({cn0, cn1, cn2, cn3} !== {4{want[k]}}) begin
        errors++; $display("FAIL cnt_edge%0d got %h want %h", k + 1, {cn0, cn1, cn2, cn3},
                           {4{want[k]}});
      end
    end
    checks++;
    if ({cf0, cf1, cf2, cf3} !== {4{8'h01}}) begin
      errors++; $display("FAIL cnt_flag got %h want %h", {cf0, cf1, cf2, cf3}, {4{8'h01}});
    end
    // ACK together with a new conflict on channel 1.
    drive(8'h02, 8'h02, 8'h02, 1'b0, 1'b1);
    step();
    checks++;
    if ({cn0, cn1, cn2, cn3} !== {4{ecnt(1)}}) begin
      errors++; $display("FAIL cnt_ack_conflict got %h want %h", {cn0, cn1, cn2, cn3}, {4{ecnt(1)}});
    end
    checks++;
    if ({cf0, cf1, cf2, cf3} !== {4{8'h02}}) begin
      errors++; $display("FAIL flag_ack_conflict got %h want %h", {cf0, cf1, cf2, cf3}, {4{8'h02}});
    end
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    step();
    checks++;
    if ({cf0, cf1, cf2, cf3, cn0, cn1, cn2, cn3} !== 40'h0) begin
      errors++; $display("FAIL cnt_ack_alone got %h want 0", {cf0, cf1, cf2, cf3, cn0, cn1, cn2, cn3});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    #12;
    rst_n = 1'b1;
    step();
    test_reset();
    test_basic();
    test_forbidden();
    test_clr();
    test_counter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
